// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int   UART_DATA_W   = 8;
  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/receiver_SIPO.sv
// Serial-in parallel-out byte register; bits enter at the MSB and shift toward
// the LSB, so after eight shifts the first bit received sits in bit 0.
module receiver_SIPO
  import uart_pkg::*;
(
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   serial_i,
  input  logic                   shift_en,
  input  logic                   clear,
  output logic [UART_DATA_W-1:0] data_o
);

  logic [UART_DATA_W-1:0] shift_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shift_q <= '0;
    end else if (clear) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {serial_i, shift_q[UART_DATA_W-1:1]};
    end
  end

  assign data_o = shift_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronizer, mid-bit sampling FSM and registered status pulses.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   rx_i,
  output logic [UART_DATA_W-1:0] data_o,
  output logic                   valid_o,
  output logic                   frame_err_o,
  output logic                   parity_err_o,
  output logic                   busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_W - 1);

  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   rx_meta_q, rx_s_q;
  logic                   shift_en, sipo_clear;
  logic [UART_DATA_W-1:0] sipo_data;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif

  // Two-flop synchronizer; resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_q <= UART_IDLE_LVL;
      rx_s_q    <= UART_IDLE_LVL;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  receiver_SIPO u_sipo (
    .clk      (clk),
    .nrst     (nrst),
    .serial_i (rx_s_q),
    .shift_en (shift_en),
    .clear    (sipo_clear),
    .data_o   (sipo_data)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    shift_en   = 1'b0;
    sipo_clear = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      // Re-check the line at half a bit so short glitches are rejected.
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d    = DATA;
            idx_d      = '0;
            sipo_clear = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          idx_d    = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      // Leaving at mid stop bit lets IDLE catch a back-to-back start edge.
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = sipo_data;
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{sipo_data, par_q}) perr_d = 1'b1;
            else                     valid_d = 1'b1;
`else
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive path: the counterpart of the transmit shift register on the far end of the serial line. Synchronises the asynchronous `rx_i` line, detects a start bit, samples each bit at mid-bit using a clock-count bit timer, and deserialises LSB-first into a byte. Presents each completed byte with a one-cycle `valid_o` strobe, and flags framing and (optionally) parity errors.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period. Must be ≥ 4.
- `clk`  in  1  system clock, rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `rx_i`  in  1  serial line; idle high; asynchronous to `clk`.
- `data_o`  out  8  last received byte, LSB received first. Reset `8'h00`.
- `valid_o`  out  1  one-cycle pulse when `data_o` has just been updated by a good frame. Reset 0.
- `frame_err_o`  out  1  one-cycle pulse when the stop bit is sampled low. Reset 0.
- `parity_err_o`  out  1  one-cycle pulse on a parity mismatch. Always 0 without the macro. Reset 0.
- `busy_o`  out  1  high whenever state ≠ IDLE. Reset 0.
- One clock; reset is asynchronous and active-low (`clk`, `nrst`).

## Operation
- `rx_i` passes through a 2-flop synchronizer. Both flops reset to 1. Call the output `rx_s`. All decisions use `rx_s` only.
- Bit timer `cnt` counts 0..CLKS_PER_BIT-1. `H = CLKS_PER_BIT/2` (floor).
- States:
  - IDLE: `cnt`=0. On `rx_s`==0, go to START.
  - START: on `cnt`==H-1, sample `rx_s`. If 0, go to DATA, clear `cnt` and the bit index. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: on `cnt`==CLKS_PER_BIT-1, sample `rx_s` into the shift register (shift right, new bit enters bit 7) and increment the bit index. After the 8th bit, go to STOP, or to PARITY if the macro is set.
  - PARITY: sample at the same point and record the result. Go to STOP.
  - STOP: sample at the same point.
    - If 1: load `data_o` from the shift register, then pulse `valid_o`, or pulse `parity_err_o` instead on a mismatch (`data_o` is still loaded). Go to IDLE.
    - If 0: pulse `frame_err_o`. Leave `data_o` unchanged. Go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from being re-read as a new start bit.
- `valid_o`, `frame_err_o` and `parity_err_o` are mutually exclusive.
- `data_o` holds its value until the next good frame or parity-error frame.
- There is no backpressure. A consumer that misses a `valid_o` pulse loses the byte.
- `nrst` asserted mid-frame: all state is cleared immediately and the partial byte is discarded. After release, a frame already in progress is received only if `rx_s` is seen low in IDLE. It is normally mis-sampled or taken as a glitch and must not hang the block.

## Timing
- t0 = first cycle in IDLE with `rx_s`==0. `rx_s` lags `rx_i` by 2 cycles.
- Samples occur at t0 + H + k·CLKS_PER_BIT:
  - k=0: start bit.
  - k=1..8: data bits.
  - k=9: stop bit, or parity bit when the macro is set.
  - k=10: stop bit when the macro is set.
- Status pulses and the `data_o` update are registered and appear the cycle after the stop sample.
- Back-to-back frames are supported. IDLE is re-entered within the stop bit, so the next start edge is caught.
- `busy_o` rises the cycle after t0. It falls with the status pulse, or when leaving BREAK.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A parity bit follows the 8 data bits. Frames are 11 bits.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - A mismatch with a good stop bit gives `parity_err_o` instead of `valid_o`.
  - A bad stop bit gives `frame_err_o` only.
- Not defined: frames are 10 bits (8N1). The PARITY state is never entered. `parity_err_o` is tied 0.

## Structure
- Package `uart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK).
  - `UART_DATA_W` = 8.
  - `UART_IDLE_LVL` = 1'b1.
- Sub-module `receiver_SIPO`: 8-bit serial-in parallel-out register.
  - Ports: `clk`, `nrst`, `serial_i`, `shift_en`, `clear`, `data_o`.
  - `clear` has priority over `shift_en`.
  - Mirrors the transmit-side shift register.
- The top module holds the synchronizer, bit timer, bit index, FSM and output registers.

## Test plan
- CLKS_PER_BIT=8, 8N1 frame 0xA5 → one `valid_o` pulse at t0+4+72+1. `data_o`=0xA5. No error pulses.
- `rx_i` low for 2 cycles, then high → no outputs. `busy_o` returns to 0 within H+1 cycles.
- Frame 0x3C with stop bit 0, line held low 40 cycles → `frame_err_o` pulse, `data_o` keeps its previous value, no `valid_o`. Stays in BREAK until the line goes high. A following 0x81 frame then gives `valid_o` with `data_o`=0x81.
- Back-to-back 0x00 then 0xFF, each with exactly one stop bit → two `valid_o` pulses exactly 10·CLKS_PER_BIT apart, with the correct bytes.
- `nrst` pulsed during bit 4 of a frame → all outputs 0 immediately. No `valid_o` for that frame. The next clean frame 0x5A is received correctly.
- `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → `valid_o`. 0x07 with parity bit 0 → `parity_err_o`, `data_o`=0x07.
